// File: rtl/alu_exec_stage_if.sv
// Purpose: operation/result handshake bundle for the ALU execute stage.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_exec_stage_if;
  // request side
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [63:0] a;
  logic [63:0] b;
  // result side
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal_op;

  // master drives operations and consumes results
  modport master (
    output in_valid, Operation, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );

  // slave is the execute stage itself
  modport slave (
    input  in_valid, Operation, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Purpose: 64-bit ALU execute stage (AND/OR/ADD/SUB/signed SLT) with registered result and flags.
// Latency: 1 cycle from accept to out_valid when the stage is empty.
// Backpressure: default one entry, in_ready = !out_valid || out_ready; ALU_EXEC_SKID_EN adds a skid entry and a registered in_ready.
module alu_exec_stage (
  input logic         clk,
  input logic         reset_n,
  alu_exec_stage_if.slave io
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0100;

  logic [63:0] alu_dat;
  logic        alu_ill;
  logic        in_rdy;
  logic        in_fire;
  logic        out_fire;

  logic        out_vld_q;
  logic [63:0] out_dat_q;
  logic        out_zero_q;
  logic        out_ill_q;

  // Combinational ALU; unknown codes yield zero result and the illegal flag.
  always_comb begin
    alu_dat = 64'd0;
    alu_ill = 1'b0;
    case (io.Operation)
      OP_AND:  alu_dat = io.a & io.b;
      OP_OR:   alu_dat = io.a | io.b;
      OP_ADD:  alu_dat = io.a + io.b;
      OP_SUB:  alu_dat = io.a - io.b;
      OP_SLT:  alu_dat = ($signed(io.a) < $signed(io.b)) ? 64'd1 : 64'd0;
      default: alu_ill = 1'b1;
    endcase
  end

  assign in_fire  = io.in_valid && in_rdy;
  assign out_fire = out_vld_q && io.out_ready;

`ifdef ALU_EXEC_SKID_EN
  logic        skid_vld_q;
  logic [63:0] skid_dat_q;
  logic        skid_zero_q;
  logic        skid_ill_q;
  logic        in_rdy_q;

  // in_ready comes straight from a flop so out_ready never reaches upstream combinationally.
  assign in_rdy = in_rdy_q;

  // Output register plus skid entry; a stalled accept parks in skid, which drains first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q   <= 1'b0;
      out_dat_q   <= 64'd0;
      out_zero_q  <= 1'b0;
      out_ill_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= 64'd0;
      skid_zero_q <= 1'b0;
      skid_ill_q  <= 1'b0;
      in_rdy_q    <= 1'b1;
    end else if (skid_vld_q) begin
      // in_ready is low here, so only the drain can happen
      if (out_fire) begin
        out_dat_q  <= skid_dat_q;
        out_zero_q <= skid_zero_q;
        out_ill_q  <= skid_ill_q;
        skid_vld_q <= 1'b0;
        in_rdy_q   <= 1'b1;
      end
    end else if (in_fire) begin
      if (!out_vld_q || io.out_ready) begin
        out_vld_q  <= 1'b1;
        out_dat_q  <= alu_dat;
        out_zero_q <= (alu_dat == 64'd0);
        out_ill_q  <= alu_ill;
      end else begin
        skid_vld_q  <= 1'b1;
        skid_dat_q  <= alu_dat;
        skid_zero_q <= (alu_dat == 64'd0);
        skid_ill_q  <= alu_ill;
        in_rdy_q    <= 1'b0;
      end
    end else if (out_fire) begin
      out_vld_q <= 1'b0;
    end
  end
`else
  // Single entry: accept when empty or when the current entry leaves this cycle.
  assign in_rdy = !out_vld_q || io.out_ready;

  // Output register; a new accept overwrites the entry being delivered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= 64'd0;
      out_zero_q <= 1'b0;
      out_ill_q  <= 1'b0;
    end else if (in_fire) begin
      out_vld_q  <= 1'b1;
      out_dat_q  <= alu_dat;
      out_zero_q <= (alu_dat == 64'd0);
      out_ill_q  <= alu_ill;
    end else if (out_fire) begin
      out_vld_q <= 1'b0;
    end
  end
`endif

  assign io.in_ready   = in_rdy;
  assign io.out_valid  = out_vld_q;
  assign io.result     = out_dat_q;
  assign io.zero       = out_zero_q;
  assign io.illegal_op = out_ill_q;

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001: The module SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset_n  input  1  asynchronous active-low reset.
REQ-004: in_valid  input  1  upstream presents an operation this cycle.
REQ-005: in_ready  output  1  stage can accept an operation this cycle.
REQ-006: Operation  input  4  ALU control code from ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 signed less-than.
REQ-007: a  input  64  operand A.
REQ-008: b  input  64  operand B.
REQ-009: out_valid  output  1  result/flags hold a valid entry.
REQ-010: out_ready  input  1  downstream consumes the entry this cycle.
REQ-011: result  output  64  registered ALU result.
REQ-012: zero  output  1  registered flag, result == 0.
REQ-013: illegal_op  output  1  registered flag, Operation not in the REQ-006 set.

Function
REQ-014: An input transfer SHALL occur on a rising edge where in_valid && in_ready; an output transfer SHALL occur where out_valid && out_ready.
REQ-015: Latency SHALL be exactly 1 cycle: an operation accepted at edge N SHALL appear with out_valid=1 after edge N, when the stage was empty.
REQ-016: AND/OR SHALL be bitwise; ADD/SUB SHALL be 64-bit modulo 2^64, with carry/borrow discarded and no overflow flag.
REQ-017: Less-than SHALL compare a and b as signed two's complement; result = 64'd1 if a<b, else 64'd0.
REQ-018: An undefined Operation code SHALL produce result=0, zero=1, illegal_op=1, and SHALL still be accepted and delivered.
REQ-019: Output registers SHALL hold their values stable while out_valid && !out_ready.
REQ-020: Entries SHALL be delivered in acceptance order; none SHALL be dropped or duplicated.
REQ-021: Simultaneous input and output transfer in one cycle SHALL replace the delivered entry with the new one; out_valid SHALL stay 1.
REQ-022: in_valid without in_ready SHALL NOT change state; upstream holds its inputs stable until accepted.
REQ-023: When out_valid=0, result, zero, and illegal_op SHALL be don't-care but SHALL NOT be X after reset.

Reset
REQ-024: On reset_n low, independent of clk: out_valid=0, result=0, zero=0, illegal_op=0, and all buffer entries invalid.
REQ-025: Reset during a pending output SHALL discard the entry; after reset_n rises, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-026: Macro ALU_EXEC_SKID_EN SHALL select the buffering scheme.
REQ-027: Without ALU_EXEC_SKID_EN, the stage SHALL hold one entry, and in_ready = !out_valid || out_ready, combinationally.
REQ-028: With ALU_EXEC_SKID_EN, the stage SHALL add a second skid entry and in_ready SHALL be a register output with no combinational path from out_ready.
REQ-029: In skid mode, in_ready SHALL be 1 whenever the skid entry is empty. A stalled accept SHALL fill the skid entry, and in_ready SHALL deassert the next cycle.
REQ-030: In skid mode, the skid entry SHALL move to the output register on the first output transfer; full throughput SHALL be 1 op/cycle.

Verification
REQ-031: Reset, then a=5, b=7, Operation=0010, in_valid=1, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, illegal_op=0.
REQ-032: Two back-to-back ops are sent with out_ready=1:
- SUB with a=9, b=9 -> result=0, zero=1.
- Less-than with a=-1, b=1 -> result=1.
- Both ops SHALL appear on consecutive cycles.
REQ-033: Hold out_ready=0 for 3 cycles after accepting AND with a=0xF0, b=0x3C:
- result=0x30 SHALL stay stable.
- in_ready=0 (single mode), or 1 then 0 after a second accept (skid mode).
- Release delivers in order.
REQ-034: Operation=1111, a=b=1 -> result=0, zero=1, illegal_op=1, delivered normally.
REQ-035: Assert reset_n=0 mid-stall with an entry pending -> out_valid=0 immediately. After release, in_ready=1 and no stale entry appears.
REQ-036: ADD with a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1 (wrap-around).
